// File: rtl/sha_padder.sv
// sha_padder: FIPS 180-4 message padder that turns a 64-bit word stream into
// 512/1024-bit SHA blocks, holding one block at a time for the engine.
package sha;
    typedef enum logic [2:0] {sha1, sha224, sha256, sha384, sha512, sha512_224, sha512_256} mode_t;
    typedef logic [1023:0] msg_t;
    function automatic logic is_wide(mode_t m);
        return m inside {sha384, sha512, sha512_224, sha512_256};
    endfunction
endpackage

module sha_padder (
    input  logic        clk,
    input  logic        rstn,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [63:0] s_data,
    input  logic        s_last,
    input  logic [3:0]  s_bytes,
    input  sha::mode_t  s_mode,
    output logic        blk_valid,
    input  logic        blk_ready,
    output logic        blk_new_msg,
    output sha::mode_t  blk_mode,
    output sha::msg_t   blk_msg
);
    localparam logic [1:0] ST_FILL = 2'd0, ST_SEND = 2'd1, ST_LENBLK = 2'd2;

    logic [1:0] state;
    logic [1023:0] nb, nxt, lb, placed;
    logic [3:0] idx, nbytes;
    logic [60:0] byte_cnt, cnt_nxt;
    logic in_msg, new_msg, last_blk, len_pend, pad_pend;
    sha::mode_t mode, cur_mode;
    logic wide, last_slot, fits;
    logic [6:0] base;
    logic [7:0] p;
    logic [63:0] masked;
    logic [127:0] word;

    // Buffer is kept in block byte order (byte 0 at [1023:1016]); 512-bit modes use the top half.
    function automatic logic [1023:0] with_len(logic [1023:0] b, logic w, logic [63:0] len);
        return w ? {b[1023:64], len} : {b[1023:576], len, b[511:0]};
    endfunction

    assign s_ready = state == ST_FILL;
    assign blk_valid = state == ST_SEND;
    assign blk_new_msg = new_msg;
    assign blk_mode = mode;
    assign blk_msg = sha::is_wide(mode) ? nb : {512'b0, nb[1023:512]};

    assign cur_mode = in_msg ? mode : s_mode;
    assign wide = sha::is_wide(cur_mode);
    assign nbytes = s_last ? s_bytes : 4'd8;
    assign base = {idx, 3'b0};
    assign p = {1'b0, base} + {4'b0, nbytes};
    assign last_slot = idx == (wide ? 4'd15 : 4'd7);
    assign cnt_nxt = byte_cnt + 61'(nbytes);
    assign fits = ({1'b0, p} + (wide ? 9'd16 : 9'd8)) < (wide ? 9'd128 : 9'd64);
    assign masked = s_data & ~(64'hFFFF_FFFF_FFFF_FFFF >> {nbytes, 3'b0});
    // A full last word pushes the 0x80 into the following word, or out of the block entirely.
    assign word = {masked, 64'b0} | (s_last ? ({8'h80, 120'b0} >> {nbytes, 3'b0}) : 128'b0);
    assign placed = {word, 896'b0} >> {base, 3'b0};
    assign nxt = (s_last && fits) ? with_len(nb | placed, wide, {cnt_nxt, 3'b0}) : nb | placed;
    assign lb = with_len({pad_pend, 1023'b0}, sha::is_wide(mode), {byte_cnt, 3'b0});

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= ST_FILL;
            nb <= '0;
            idx <= '0;
            byte_cnt <= '0;
            in_msg <= 1'b0;
            new_msg <= 1'b0;
            last_blk <= 1'b0;
            len_pend <= 1'b0;
            pad_pend <= 1'b0;
            mode <= sha::sha1;
        end else begin
            case (state)
                ST_FILL: if (s_valid) begin
                    nb <= nxt;
                    byte_cnt <= cnt_nxt;
                    idx <= idx + 4'd1;
                    if (!in_msg) begin
                        mode <= s_mode;
                        in_msg <= 1'b1;
                        new_msg <= 1'b1;
                    end
                    if (s_last) begin
                        state <= ST_SEND;
                        last_blk <= 1'b1;
                        len_pend <= !fits;
                        pad_pend <= last_slot && nbytes == 4'd8;
                        idx <= '0;
                    end else if (last_slot) begin
                        state <= ST_SEND;
                        last_blk <= 1'b0;
                        idx <= '0;
                    end
                end
                ST_SEND: if (blk_ready) begin
                    nb <= '0;
                    new_msg <= 1'b0;
                    state <= (last_blk && len_pend) ? ST_LENBLK : ST_FILL;
                    if (last_blk && !len_pend) begin
                        byte_cnt <= '0;
                        in_msg <= 1'b0;
                    end
                end
                ST_LENBLK: begin
                    nb <= lb;
                    len_pend <= 1'b0;
                    pad_pend <= 1'b0;
                    state <= ST_SEND;
                end
                default: state <= ST_FILL;
            endcase
        end
    end
endmodule
